// File: rtl/tpu_seq_pkg.sv
// Shared definitions for the TPU job sequencer.
// Holds the job geometry (DIM, DATAW, ADDRW, WAIT_CYC), the accelerator
// address map, the sequencer state enum and a small address helper.
package tpu_seq_pkg;

  localparam int DIM      = 8;
  localparam int DATAW    = 64;
  localparam int ADDRW    = 16;
  localparam int WAIT_CYC = 3 * DIM;

  // One counter serves the load, wait and read phases, so it is sized
  // for the longest of them (the compute wait).
  localparam int CNTW = $clog2(WAIT_CYC + 1);

  localparam logic [ADDRW-1:0] A_BASE      = 16'h0100;
  localparam logic [ADDRW-1:0] B_BASE      = 16'h0200;
  localparam logic [ADDRW-1:0] C_BASE      = 16'h0300;
  localparam logic [ADDRW-1:0] MATMUL_ADDR = 16'h0400;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    LOAD_C,
    MATMUL,
    WAIT,
    READ
  } state_t;

  // Accelerator words sit on an 8-byte stride from the phase base.
  function automatic logic [ADDRW-1:0] word_addr(input logic [ADDRW-1:0] base,
                                                 input logic [CNTW-1:0]  idx);
    return base + (ADDRW'(idx) << 3);
  endfunction

endpackage

// File: rtl/tpu_job_sequencer_if.sv
// Bundles the three data paths around the job sequencer:
//   in_*   : job word stream from the host (valid/ready)
//   out_*  : result half-row stream to the host (valid/ready)
//   tpu_*  : accelerator register bus (tpu_dataOut is combinational from tpu_addr)
// Modport master is the sequencer view, slave is the host/accelerator view.
interface tpu_job_sequencer_if;
  import tpu_seq_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [DATAW-1:0] in_data;

  logic             out_valid;
  logic             out_ready;
  logic [DATAW-1:0] out_data;

  logic             tpu_r_w;
  logic [ADDRW-1:0] tpu_addr;
  logic [DATAW-1:0] tpu_dataIn;
  logic [DATAW-1:0] tpu_dataOut;

  modport master (
    input  in_valid, in_data, out_ready, tpu_dataOut,
    output in_ready, out_valid, out_data, tpu_r_w, tpu_addr, tpu_dataIn
  );

  modport slave (
    output in_valid, in_data, out_ready, tpu_dataOut,
    input  in_ready, out_valid, out_data, tpu_r_w, tpu_addr, tpu_dataIn
  );

endinterface

// File: rtl/tpu_seq_perf_cnt.sv
// Saturating job cycle counter for the TPU job sequencer.
// Only instantiated when TPU_SEQ_PERF_EN is defined.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   clear_i        restart the running count (job leaves IDLE)
//   inc_i          count this cycle (job busy)
//   latch_i        capture the count including this cycle (job done)
//   perf_cycles_o  last captured job cycle count
module tpu_seq_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        inc_i,
  input  logic        latch_i,
  output logic [31:0] perf_cycles_o
);

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] perf_q, perf_d;
  logic [31:0] cnt_inc;

  always_comb begin
    // Saturate rather than wrap so an overlong job never reads as short.
    cnt_inc = (inc_i && (cnt_q != 32'hFFFF_FFFF)) ? cnt_q + 32'd1 : cnt_q;
    cnt_d   = clear_i ? 32'd0 : cnt_inc;
    // The final busy cycle coincides with the latch, so capture cnt_inc.
    perf_d  = latch_i ? cnt_inc : perf_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      perf_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      perf_q <= perf_d;
    end
  end

  assign perf_cycles_o = perf_q;

endmodule

// File: rtl/tpu_job_sequencer.sv
// Upstream feeder for the matrix-multiply accelerator. Takes one job as a
// stream of 64-bit words (8 A rows, 8 B rows, 16 C half-rows), replays them
// as strictly ordered accelerator writes, issues MatMul, waits out the
// compute window and streams the 16 result half-rows back out.
// Ports:
//   clk, rst      clock, synchronous active-high reset (accelerator must be
//                 reset in the same cycle to keep its address counters aligned)
//   bus           tpu_job_sequencer_if.master: in/out streams and tpu bus
//   busy          job in progress
//   done          one-cycle pulse after the last result word is consumed
//   perf_cycles   busy-cycle count of the last job (0 unless TPU_SEQ_PERF_EN)
// Build option: define TPU_SEQ_PERF_EN to build the job cycle counter.
module tpu_job_sequencer
  import tpu_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  tpu_job_sequencer_if.master bus,
  output logic                busy,
  output logic                done,
  output logic [31:0]         perf_cycles
);

  localparam logic [CNTW-1:0] ROW_LAST  = CNTW'(DIM - 1);
  localparam logic [CNTW-1:0] HALF_LAST = CNTW'(2 * DIM - 1);
  localparam logic [CNTW-1:0] WAIT_LAST = CNTW'(WAIT_CYC - 1);

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic             accept;
  logic [ADDRW-1:0] load_base;
  logic [CNTW-1:0]  load_last;
  state_t           load_next;

  assign accept = bus.in_valid & in_ready_q;

  // Per-phase write base, word count and successor for the three load phases.
  always_comb begin
    load_base = A_BASE;
    load_last = ROW_LAST;
    load_next = LOAD_B;
    case (state_q)
      LOAD_B: begin
        load_base = B_BASE;
        load_next = LOAD_C;
      end
      LOAD_C: begin
        load_base = C_BASE;
        load_last = HALF_LAST;
        load_next = MATMUL;
      end
      default: ;
    endcase
  end

  // Next-state logic plus the combinational accelerator drive. Any cycle
  // without an explicit access falls back to address 0 / read, which the
  // accelerator never decodes.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    done_d         = 1'b0;
    bus.tpu_r_w    = 1'b0;
    bus.tpu_addr   = '0;
    bus.tpu_dataIn = '0;

    case (state_q)
      IDLE: begin
        // The first word only wakes the sequencer; it is accepted next cycle.
        if (bus.in_valid) begin
          state_d = LOAD_A;
          cnt_d   = '0;
        end
      end
      LOAD_A, LOAD_B, LOAD_C: begin
        if (accept) begin
          bus.tpu_r_w    = 1'b1;
          bus.tpu_addr   = word_addr(load_base, cnt_q);
          bus.tpu_dataIn = bus.in_data;
          if (cnt_q == load_last) begin
            cnt_d   = '0;
            state_d = load_next;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end
      MATMUL: begin
        bus.tpu_addr = MATMUL_ADDR;
        cnt_d        = '0;
        state_d      = WAIT;
      end
      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = READ;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      READ: begin
        bus.tpu_addr = word_addr(C_BASE, cnt_q);
        if (bus.out_ready && out_valid_q) begin
          if (cnt_q == HALF_LAST) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Status outputs are registered, so derive them from the next state.
    in_ready_d  = (state_d == LOAD_A) || (state_d == LOAD_B) || (state_d == LOAD_C);
    out_valid_d = (state_d == READ);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Result data comes straight off the accelerator read port; the address
  // holds while out_ready is low, so the data holds too.
  assign bus.out_data  = (state_q == READ) ? bus.tpu_dataOut : '0;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;

`ifdef TPU_SEQ_PERF_EN
  logic leave_idle;
  assign leave_idle = (state_q == IDLE) && (state_d != IDLE);

  tpu_seq_perf_cnt u_perf_cnt (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (leave_idle),
    .inc_i         (busy_q),
    .latch_i       (done_d),
    .perf_cycles_o (perf_cycles)
  );
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_tpu_job_sequencer.sv
// Self-checking bench for tpu_job_sequencer. Contains a behavioural
// accelerator (strict in-order writes, MatMul C = A*B + C in 16-bit lanes,
// combinational C reads) and runs directed jobs: identity, input gaps,
// output stall, reset mid-load and back-to-back jobs.
module tb_tpu_job_sequencer;
  import tpu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic        done;
  logic [31:0] perf_cycles;

  tpu_job_sequencer_if bus ();

  tpu_job_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .perf_cycles (perf_cycles)
  );

  always #5 clk = ~clk;

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt++;

  int check_count = 0;
  int error_count = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Expected accelerator write address for the n-th write of a job.
  function automatic logic [15:0] expectedWrAddr(input int n);
    if (n < 8)       return 16'h0100 + 16'(8 * n);
    else if (n < 16) return 16'h0200 + 16'(8 * (n - 8));
    else             return 16'h0300 + 16'(8 * (n - 16));
  endfunction

  // Behavioural accelerator
  logic [63:0] amem [8]  = '{default: 64'h0};
  logic [63:0] bmem [8]  = '{default: 64'h0};
  logic [63:0] cmem [16] = '{default: 64'h0};
  logic [63:0] new_c [16];
  logic [15:0] mac;
  int          wr_ptr = 0;
  int          matmul_total = 0;
  int          leak_total = 0;
  logic [15:0] wr_log [$];

  always @(negedge clk) begin
    if (rst) begin
      wr_ptr = 0;
    end else begin
      if (bus.tpu_r_w) begin
        wr_log.push_back(bus.tpu_addr);
        if (wr_ptr < 32 && bus.tpu_addr == expectedWrAddr(wr_ptr)) begin
          if (wr_ptr < 8)       amem[wr_ptr] = bus.tpu_dataIn;
          else if (wr_ptr < 16) bmem[wr_ptr - 8] = bus.tpu_dataIn;
          else                  cmem[wr_ptr - 16] = bus.tpu_dataIn;
          wr_ptr++;
        end
      end else if (bus.tpu_dataIn != 64'h0) begin
        leak_total++;
      end
      if (!bus.tpu_r_w && bus.tpu_addr == 16'h0400) begin
        matmul_total++;
        for (int i = 0; i < 8; i++) begin
          for (int j = 0; j < 8; j++) begin
            mac = cmem[2*i + j/4][(j%4)*16 +: 16];
            for (int k = 0; k < 8; k++)
              mac = mac + 16'(amem[i][8*k +: 8]) * 16'(bmem[k][8*j +: 8]);
            new_c[2*i + j/4][(j%4)*16 +: 16] = mac;
          end
        end
        for (int w = 0; w < 16; w++) cmem[w] = new_c[w];
        wr_ptr = 0;
      end
    end
  end

  always_comb begin
    bus.tpu_dataOut = 64'h0;
    if (bus.tpu_addr >= 16'h0300 && bus.tpu_addr <= 16'h0378 && bus.tpu_addr[2:0] == 3'b000)
      bus.tpu_dataOut = cmem[bus.tpu_addr[6:3]];
  end

  // Job description and expected results
  logic [63:0] job_words [32];
  logic [63:0] exp_res [16];
  int          job_start = -1;
  bit          held_prev = 1'b0;
  int          prev_done = 0;

  task automatic makeIdentityJob();
    for (int i = 0; i < 8; i++) begin
      job_words[i] = 64'h1 << (8 * i);
      for (int j = 0; j < 8; j++) job_words[8 + i][8*j +: 8] = 8'(8 * i + j + 1);
    end
    for (int w = 0; w < 16; w++) job_words[16 + w] = 64'h0;
    // A = I, C = 0: result lane j of row i is B[i][j] = 8i+j+1.
    for (int i = 0; i < 8; i++) begin
      exp_res[2*i]     = {16'(8*i + 4), 16'(8*i + 3), 16'(8*i + 2), 16'(8*i + 1)};
      exp_res[2*i + 1] = {16'(8*i + 8), 16'(8*i + 7), 16'(8*i + 6), 16'(8*i + 5)};
    end
  endtask

  task automatic makeRandomJob();
    logic [15:0] acc;
    for (int w = 0; w < 32; w++) job_words[w] = {$urandom, $urandom};
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        acc = job_words[16 + 2*i + j/4][(j%4)*16 +: 16];
        for (int k = 0; k < 8; k++)
          acc = acc + 16'(job_words[i][8*k +: 8]) * 16'(job_words[8 + k][8*j +: 8]);
        exp_res[2*i + j/4][(j%4)*16 +: 16] = acc;
      end
    end
  endtask

  task automatic checkResetValues();
    checkOutput("rst_in_ready", {63'h0, bus.in_ready}, 64'h0);
    checkOutput("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
    checkOutput("rst_busy", {63'h0, busy}, 64'h0);
    checkOutput("rst_done", {63'h0, done}, 64'h0);
    checkOutput("rst_tpu_r_w", {63'h0, bus.tpu_r_w}, 64'h0);
    checkOutput("rst_tpu_addr", {48'h0, bus.tpu_addr}, 64'h0);
    checkOutput("rst_tpu_dataIn", bus.tpu_dataIn, 64'h0);
    checkOutput("rst_perf", {32'h0, perf_cycles}, 64'h0);
  endtask

  // Streams job words until 'limit' are accepted (bounded).
  task automatic loadWords(input bit gaps, input int limit, output int idx, output int first_acc);
    int cyc;
    bit acc;
    idx = 0;
    cyc = 0;
    first_acc = -1;
    while (idx < limit && cyc < 400) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 64'h0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = job_words[idx];
        if (job_start < 0) job_start = cycle_cnt;
      end
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (acc && first_acc < 0) first_acc = cycle_cnt;
      @(posedge clk);
      #1;
      if (acc) idx++;
      cyc++;
    end
  endtask

  // Runs one complete job and checks writes, results, timing and status.
  task automatic applyStimulus(input bit gaps, input int stall_k, input int stall_len,
                               input bit hold_after, input logic [63:0] hold_word,
                               input int exp_cycles);
    int idx, first_acc, k, cyc, stall_left, ready_viol, done_cyc;
    int wr_base, mm_base, leak_base, n_wr;
    logic [31:0] exp_perf;
    wr_base   = wr_log.size();
    mm_base   = matmul_total;
    leak_base = leak_total;
    job_start = held_prev ? prev_done : -1;

    loadWords(gaps, 32, idx, first_acc);
    checkOutput("load_words", 64'(idx), 64'd32);
    if (!gaps) checkOutput("first_accept_delay", 64'(first_acc - job_start), 64'd1);

    bus.in_valid = hold_after;
    bus.in_data  = hold_after ? hold_word : 64'h0;

    k = 0;
    cyc = 0;
    stall_left = stall_len;
    ready_viol = 0;
    while (k < 16 && cyc < 200) begin
      bus.out_ready = !(bus.out_valid && k == stall_k && stall_left > 0);
      @(negedge clk);
      if (bus.in_ready) ready_viol++;
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          checkOutput("rd_addr", {48'h0, bus.tpu_addr}, {48'h0, 16'h0300 + 16'(8 * k)});
          checkOutput("rd_data", bus.out_data, exp_res[k]);
          k++;
        end else begin
          checkOutput("stall_addr", {48'h0, bus.tpu_addr}, {48'h0, 16'h0300 + 16'(8 * k)});
          checkOutput("stall_data", bus.out_data, exp_res[k]);
          stall_left--;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("read_words", 64'(k), 64'd16);
    checkOutput("in_ready_low_after_load", 64'(ready_viol), 64'd0);
    bus.out_ready = 1'b0;

    @(negedge clk);
    done_cyc = cycle_cnt;
    checkOutput("done_pulse", {63'h0, done}, 64'h1);
    checkOutput("busy_at_done", {63'h0, busy}, 64'h0);
    checkOutput("out_valid_at_done", {63'h0, bus.out_valid}, 64'h0);
`ifdef TPU_SEQ_PERF_EN
    exp_perf = 32'(done_cyc - job_start - 1);
`else
    exp_perf = 32'h0;
`endif
    checkOutput("perf_cycles", {32'h0, perf_cycles}, {32'h0, exp_perf});
    if (exp_cycles > 0) checkOutput("job_cycles", 64'(done_cyc - job_start), 64'(exp_cycles));

    n_wr = wr_log.size() - wr_base;
    checkOutput("wr_count", 64'(n_wr), 64'd32);
    for (int n = 0; n < n_wr && n < 32; n++)
      checkOutput("wr_addr", {48'h0, wr_log[wr_base + n]}, {48'h0, expectedWrAddr(n)});
    checkOutput("matmul_cycles", 64'(matmul_total - mm_base), 64'd1);
    checkOutput("datain_zero_on_read", 64'(leak_total - leak_base), 64'd0);

    @(posedge clk);
    #1;
    checkOutput("done_one_cycle", {63'h0, done}, 64'h0);
    held_prev = hold_after;
    prev_done = done_cyc;
  endtask

  // Loads part of a job, then pulses rst (with accelerator reset) mid-phase.
  task automatic abortJob(input int at_word);
    int idx, first_acc;
    job_start = -1;
    held_prev = 1'b0;
    loadWords(1'b0, at_word, idx, first_acc);
    checkOutput("abort_progress", 64'(idx), 64'(at_word));
    bus.in_valid = 1'b1;
    bus.in_data  = job_words[at_word];
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 64'h0;
    @(negedge clk);
    checkResetValues();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 64'h0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkResetValues();
    @(posedge clk);
    #1;

    $display("[TB] identity job");
    makeIdentityJob();
    applyStimulus(1'b0, -1, 0, 1'b0, 64'h0, 74);

    $display("[TB] random job with input gaps");
    makeRandomJob();
    applyStimulus(1'b1, -1, 0, 1'b0, 64'h0, 0);

    $display("[TB] random job with out_ready stall at k=3");
    makeRandomJob();
    applyStimulus(1'b0, 3, 5, 1'b0, 64'h0, 79);

    $display("[TB] reset during LOAD_B word 4");
    makeRandomJob();
    abortJob(12);
    makeRandomJob();
    applyStimulus(1'b0, -1, 0, 1'b0, 64'h0, 74);

    $display("[TB] back-to-back jobs with in_valid held");
    makeRandomJob();
    applyStimulus(1'b0, -1, 0, 1'b1, 64'hDEAD_BEEF_0BAD_F00D, 74);
    makeRandomJob();
    applyStimulus(1'b0, -1, 0, 1'b0, 64'h0, 74);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
